mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory access controller sitting directly downstream of the instruction sequencer/decoder: it turns the sequencer's level-sensitive `Mem_OE` / `Mem_WE` requests plus the MAR/MDR contents into properly timed asynchronous SRAM strobes with programmable wait states. It returns read data toward the MDR input mux with a one-cycle `Mem_Ready` pulse. It also decodes the memory-mapped I/O word at 0xFFFF, mapping switches on read and the hex display register on write.

## Interface
- `WAIT_CYCLES`, default 2: SRAM strobe width in clock cycles; legal range 1..15.
- `MMIO_ADDR`, default 16'hFFFF: memory-mapped I/O word address.

- `Clk`  in  1  system clock, all state on rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `Mem_OE`  in  1  read request from sequencer, level, held until `Mem_Ready` seen
- `Mem_WE`  in  1  write request from sequencer, level, same rule
- `MAR`  in  16  access address
- `MDR`  in  16  write data
- `Data_from_SRAM`  in  16  SRAM read bus
- `Switches`  in  16  board switches, MMIO read source
- `Data_to_CPU`  out  16  read data to MDR mux, registered, held between accesses
- `Data_to_SRAM`  out  16  write data, registered
- `ADDR`  out  20  SRAM address = {4'b0000, MAR latched}
- `CE_N`, `UB_N`, `LB_N`, `OE_N`, `WE_N`  out  1 each  SRAM strobes, active-low
- `HEX_Data`  out  16  MMIO display register
- `Mem_Ready`  out  1  one-cycle completion pulse
- `Busy`  out  1  high in any state except IDLE

## Operation
- States: IDLE, RD_ACT, WR_SETUP, WR_PULSE, WR_HOLD, DONE. 4-bit wait counter.
- IDLE: on an edge with `Mem_WE`=1, latch MAR into `ADDR` and MDR into `Data_to_SRAM`, then go to WR_SETUP. Otherwise, if `Mem_OE`=1, latch MAR and go to RD_ACT.
- Both requests high at once: write wins; OE is ignored for that access.
- RD_ACT: CE_N/UB_N/LB_N/OE_N=0 and counter increments. At the edge where counter==WAIT_CYCLES-1, capture `Data_from_SRAM` into `Data_to_CPU` and go to DONE.
- WR_SETUP: 1 cycle, CE_N/UB_N/LB_N=0, WE_N=1.
- WR_PULSE: WAIT_CYCLES cycles with WE_N=0.
- WR_HOLD: 1 cycle with WE_N=1, data and address still driven, then go to DONE.
- DONE: `Mem_Ready`=1 only in the first DONE cycle. Stay in DONE while either request is high, and return to IDLE the edge after both are low. This prevents retriggering while the sequencer holds `Mem_OE` across its wait states.
- All strobes are high in IDLE and DONE. `ADDR` and `Data_to_SRAM` hold their last values.
- MAR/MDR changes after latch have no effect until the next access.

## Timing
- Reset (asynchronous): state IDLE, counter 0, all `_N` outputs 1, `Mem_Ready`=0, `Busy`=0, `Data_to_CPU`=0, `Data_to_SRAM`=0, `ADDR`=0, `HEX_Data`=0.
- Reset mid-write: WE_N goes high immediately, with no clock needed.
- Read latency: request sampled at edge k; `Mem_Ready` high during cycle k+WAIT_CYCLES to k+WAIT_CYCLES+1; `Data_to_CPU` valid from the same edge.
- Write latency: `Mem_Ready` high during cycle k+WAIT_CYCLES+2 to k+WAIT_CYCLES+3.
- MMIO access: `Mem_Ready` high during cycle k to k+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `MEM_MMIO_EN` defined: a MAR==MMIO_ADDR access never touches SRAM. IDLE goes straight to DONE with no strobes.
  - MMIO read: `Data_to_CPU` <= `Switches`.
  - MMIO write: `HEX_Data` <= `MDR`.
- `MEM_MMIO_EN` undefined: MMIO_ADDR is an ordinary SRAM address, and `HEX_Data` is tied to 0.

## Test plan
- Reset, then read with WAIT_CYCLES=2, MAR=16'h0010, SRAM returns 16'h1234: OE_N low for exactly 2 cycles, `Data_to_CPU`=16'h1234, one `Mem_Ready` pulse at k+2.
- Write with MAR=16'h0020, MDR=16'hBEEF: WE_N low exactly 2 cycles, bracketed by one setup and one hold cycle with CE_N=0. `Data_to_SRAM`=16'hBEEF throughout, `ADDR`=20'h00020, `Mem_Ready` pulse at k+4.
- `Mem_OE` held 4 cycles past `Mem_Ready`: no second access and no second pulse. IDLE is reached one edge after OE drops.
- `Mem_OE` and `Mem_WE` asserted together: only a write occurs and OE_N stays 1.
- `MEM_MMIO_EN` defined:
  - Read at 16'hFFFF with `Switches`=16'h00A5: `Data_to_CPU`=16'h00A5 and `Mem_Ready` at k, with CE_N staying 1.
  - Write at 16'hFFFF with MDR=16'h0042: `HEX_Data`=16'h0042.
- `Reset` asserted in the middle of WR_PULSE: WE_N high asynchronously. After release, the block sits in IDLE with all outputs at their reset values.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Bus between the instruction sequencer and the SRAM/MMIO side of mem_access_ctrl.
// The master drives requests and external data; the slave (the controller) drives strobes and results.
interface mem_access_ctrl_if;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] Data_from_SRAM;
  logic [15:0] Switches;
  logic [15:0] Data_to_CPU;
  logic [15:0] Data_to_SRAM;
  logic [19:0] ADDR;
  logic        CE_N;
  logic        UB_N;
  logic        LB_N;
  logic        OE_N;
  logic        WE_N;
  logic [15:0] HEX_Data;
  logic        Mem_Ready;
  logic        Busy;

  modport master (
    output Mem_OE, Mem_WE, MAR, MDR, Data_from_SRAM, Switches,
    input  Data_to_CPU, Data_to_SRAM, ADDR, CE_N, UB_N, LB_N, OE_N, WE_N,
           HEX_Data, Mem_Ready, Busy
  );

  modport slave (
    input  Mem_OE, Mem_WE, MAR, MDR, Data_from_SRAM, Switches,
    output Data_to_CPU, Data_to_SRAM, ADDR, CE_N, UB_N, LB_N, OE_N, WE_N,
           HEX_Data, Mem_Ready, Busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Turns level OE/WE requests into timed async-SRAM strobes with WAIT_CYCLES-wide pulses.
// Define MEM_MMIO_EN to map MMIO_ADDR onto Switches (read) and HEX_Data (write).
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] MMIO_ADDR   = 16'hFFFF
) (
  input logic              Clk,
  input logic              Reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD_ACT, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [15:0] data_to_cpu_reg, data_to_cpu_next;
  logic [15:0] data_to_sram_reg, data_to_sram_next;
  logic [15:0] addr_reg, addr_next;
  logic [15:0] hex_next;
  // Strobe vector order: {CE_N, UB_N, LB_N, OE_N, WE_N}
  logic [4:0]  strb_n_reg, strb_n_next;
  logic        ready_reg, ready_next;
  logic        busy_reg, busy_next;
  logic        mmio_hit;

`ifdef MEM_MMIO_EN
  logic [15:0] hex_reg;

  assign mmio_hit = (bus.MAR == MMIO_ADDR);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) hex_reg <= '0;
    else       hex_reg <= hex_next;
  end

  assign bus.HEX_Data = hex_reg;
`else
  logic [15:0] unused_mmio_addr;

  assign mmio_hit         = 1'b0;
  assign unused_mmio_addr = MMIO_ADDR;
  assign bus.HEX_Data     = '0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      data_to_cpu_reg  <= '0;
      data_to_sram_reg <= '0;
      addr_reg         <= '0;
      strb_n_reg       <= '1;
      ready_reg        <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      data_to_cpu_reg  <= data_to_cpu_next;
      data_to_sram_reg <= data_to_sram_next;
      addr_reg         <= addr_next;
      strb_n_reg       <= strb_n_next;
      ready_reg        <= ready_next;
      busy_reg         <= busy_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    data_to_cpu_next  = data_to_cpu_reg;
    data_to_sram_next = data_to_sram_reg;
    addr_next         = addr_reg;
`ifdef MEM_MMIO_EN
    hex_next          = hex_reg;
`else
    hex_next          = '0;
`endif

    case (state_reg)
      IDLE: begin
        // Write has priority when both requests arrive together
        if (bus.Mem_WE) begin
          if (mmio_hit) begin
            hex_next   = bus.MDR;
            state_next = DONE;
          end else begin
            addr_next         = bus.MAR;
            data_to_sram_next = bus.MDR;
            state_next        = WR_SETUP;
          end
        end else if (bus.Mem_OE) begin
          if (mmio_hit) begin
            data_to_cpu_next = bus.Switches;
            state_next       = DONE;
          end else begin
            addr_next  = bus.MAR;
            cnt_next   = '0;
            state_next = RD_ACT;
          end
        end
      end
      RD_ACT: begin
        if (cnt_reg == LAST_CNT) begin
          data_to_cpu_next = bus.Data_from_SRAM;
          state_next       = DONE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      WR_SETUP: begin
        cnt_next   = '0;
        state_next = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_reg == LAST_CNT) state_next = WR_HOLD;
        else                     cnt_next   = cnt_reg + 4'd1;
      end
      WR_HOLD: state_next = DONE;
      DONE: begin
        // Sequencer holds its request through its own wait states; wait for release
        if (!bus.Mem_OE && !bus.Mem_WE) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered
    strb_n_next = 5'b11111;
    case (state_next)
      RD_ACT:            strb_n_next = 5'b00001;
      WR_SETUP, WR_HOLD: strb_n_next = 5'b00011;
      WR_PULSE:          strb_n_next = 5'b00010;
      default:           strb_n_next = 5'b11111;
    endcase
    busy_next  = (state_next != IDLE);
    ready_next = (state_next == DONE) && (state_reg != DONE);
  end

  assign bus.Data_to_CPU  = data_to_cpu_reg;
  assign bus.Data_to_SRAM = data_to_sram_reg;
  assign bus.ADDR         = {4'b0000, addr_reg};
  assign bus.CE_N         = strb_n_reg[4];
  assign bus.UB_N         = strb_n_reg[3];
  assign bus.LB_N         = strb_n_reg[2];
  assign bus.OE_N         = strb_n_reg[1];
  assign bus.WE_N         = strb_n_reg[0];
  assign bus.Mem_Ready    = ready_reg;
  assign bus.Busy         = busy_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: expected completions are queued when a request is driven
// and compared when Mem_Ready appears; also covers hold-off, write priority, MMIO and async reset.
module tb_mem_access_ctrl;

  localparam int W = 2;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(
    .WAIT_CYCLES(W),
    .MMIO_ADDR  (16'hFFFF)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    int          lat;
    int          oe_cyc;
    int          we_cyc;
    int          ce_cyc;
    logic [19:0] addr;
    logic [15:0] cpu;
    logic [15:0] sram;
    logic [15:0] hex;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [19:0] m_addr = '0;
  logic [15:0] m_cpu  = '0;
  logic [15:0] m_sram = '0;
  logic [15:0] m_hex  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {bus.CE_N, bus.UB_N, bus.LB_N, bus.OE_N, bus.WE_N};
  endfunction

  task automatic access(input string tag, input bit wr, input bit rd, input logic [15:0] mar,
                        input logic [15:0] mdr, input logic [15:0] sram, input int hold);
    exp_t e;
    exp_t got;
    bit   mmio = 1'b0;
    bit   seen = 1'b0;
    bit   bad_bus = 1'b0;
    int   lat = -1;
    int   oe_c = 0;
    int   we_c = 0;
    int   ce_c = 0;
    int   pulses = 0;
    int   strobe_act = 0;
`ifdef MEM_MMIO_EN
    mmio = (mar == 16'hFFFF);
`endif
    if (wr) begin
      if (mmio) m_hex = mdr;
      else begin m_addr = {4'h0, mar}; m_sram = mdr; end
    end else if (rd) begin
      if (mmio) m_cpu = bus.Switches;
      else begin m_addr = {4'h0, mar}; m_cpu = sram; end
    end
    e.lat    = mmio ? 0 : (wr ? W + 2 : W);
    e.oe_cyc = (!wr && !mmio) ? W : 0;
    e.we_cyc = (wr && !mmio) ? W : 0;
    e.ce_cyc = mmio ? 0 : (wr ? W + 2 : W);
    e.addr   = m_addr;
    e.cpu    = m_cpu;
    e.sram   = m_sram;
    e.hex    = m_hex;

    @(negedge Clk);
    bus.Mem_WE = wr;
    bus.Mem_OE = rd;
    bus.MAR = mar;
    bus.MDR = mdr;
    bus.Data_from_SRAM = sram;
    sb_q.push_back(e);

    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (c == 0) begin
        bus.MAR = ~mar;
        bus.MDR = ~mdr;
      end
      if (!bus.OE_N) oe_c++;
      if (!bus.WE_N) we_c++;
      if (!bus.CE_N) ce_c++;
      if (!bus.CE_N && bus.ADDR !== e.addr) bad_bus = 1'b1;
      if (!bus.WE_N && bus.Data_to_SRAM !== e.sram) bad_bus = 1'b1;
      if (bus.Mem_Ready) begin
        seen = 1'b1;
        lat = c;
      end
    end

    got = sb_q.pop_front();
    check({tag, ":ready_seen"}, 32'(seen), 32'd1);
    check({tag, ":latency"}, lat, got.lat);
    check({tag, ":oe_low_cycles"}, oe_c, got.oe_cyc);
    check({tag, ":we_low_cycles"}, we_c, got.we_cyc);
    check({tag, ":ce_low_cycles"}, ce_c, got.ce_cyc);
    check({tag, ":bus_stable"}, 32'(bad_bus), 32'd0);
    check({tag, ":strobes_at_ready"}, 32'(strobes()), 32'h1F);
    check({tag, ":busy_at_ready"}, 32'(bus.Busy), 32'd1);
    check({tag, ":data_to_cpu"}, 32'(bus.Data_to_CPU), 32'(got.cpu));
    check({tag, ":data_to_sram"}, 32'(bus.Data_to_SRAM), 32'(got.sram));
    check({tag, ":addr"}, 32'(bus.ADDR), 32'(got.addr));
    check({tag, ":hex"}, 32'(bus.HEX_Data), 32'(got.hex));

    bus.Data_from_SRAM = ~sram;
    for (int h = 0; h < hold; h++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (bus.Mem_Ready) pulses++;
      if (strobes() != 5'h1F) strobe_act++;
    end
    if (hold > 0) begin
      check({tag, ":extra_ready"}, pulses, 0);
      check({tag, ":strobes_during_hold"}, strobe_act, 0);
      check({tag, ":busy_during_hold"}, 32'(bus.Busy), 32'd1);
    end

    bus.Mem_OE = 1'b0;
    bus.Mem_WE = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check({tag, ":idle_after_release"}, 32'(bus.Busy), 32'd0);
    check({tag, ":cpu_held"}, 32'(bus.Data_to_CPU), 32'(got.cpu));
    $display("txn %s wr=%0b rd=%0b mar=%h latency=%0d cpu=%h sram=%h hex=%h", tag, wr, rd, mar,
             lat, bus.Data_to_CPU, bus.Data_to_SRAM, bus.HEX_Data);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ":strobes"}, 32'(strobes()), 32'h1F);
    check({tag, ":ready_busy"}, 32'({bus.Mem_Ready, bus.Busy}), 32'd0);
    check({tag, ":data_to_cpu"}, 32'(bus.Data_to_CPU), 32'd0);
    check({tag, ":data_to_sram"}, 32'(bus.Data_to_SRAM), 32'd0);
    check({tag, ":addr"}, 32'(bus.ADDR), 32'd0);
    check({tag, ":hex"}, 32'(bus.HEX_Data), 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    bus.Mem_OE = 1'b0;
    bus.Mem_WE = 1'b0;
    bus.MAR = '0;
    bus.MDR = '0;
    bus.Data_from_SRAM = '0;
    bus.Switches = 16'h00A5;
    repeat (2) @(negedge Clk);
    check_reset_values("reset");
    Reset = 1'b0;

    access("read",  1'b0, 1'b1, 16'h0010, 16'h0000, 16'h1234, 0);
    access("write", 1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h0000, 0);
    access("hold",  1'b0, 1'b1, 16'h0030, 16'h0000, 16'h5A5A, 4);
    access("both",  1'b1, 1'b1, 16'h0050, 16'h1111, 16'h2222, 0);
`ifdef MEM_MMIO_EN
    access("mmio_rd", 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h3333, 0);
    access("mmio_wr", 1'b1, 1'b0, 16'hFFFF, 16'h0042, 16'h0000, 0);
`else
    access("ffff_rd", 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0F0F, 0);
    access("ffff_wr", 1'b1, 1'b0, 16'hFFFF, 16'h0042, 16'h0000, 0);
`endif

    // Reset in the middle of the write pulse, between clock edges
    @(negedge Clk);
    bus.Mem_WE = 1'b1;
    bus.MAR = 16'h0040;
    bus.MDR = 16'h7777;
    @(posedge Clk);
    @(negedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    check("rst_mid:we_low_before", 32'(bus.WE_N), 32'd0);
    #1 Reset = 1'b1;
    #1;
    check("rst_mid:we_async_high", 32'(bus.WE_N), 32'd1);
    check("rst_mid:ce_async_high", 32'(bus.CE_N), 32'd1);
    bus.Mem_WE = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check_reset_values("rst_mid_after");
    $display("txn rst_mid strobes=%b busy=%0b", strobes(), bus.Busy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
